// File: rtl/decode_issue_queue.sv
// Instruction queue between fetch and decode: issues legal uops, traps on illegal ones.
// Optional zero-latency fetch-to-decode path when empty: define DECODE_ISSUE_BYPASS_EN.
module decode_issue_queue #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned XLEN  = 32
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       flush_i,
    input  logic                       fetch_valid_i,
    output logic                       fetch_ready_o,
    input  logic [XLEN-1:0]            fetch_instr_i,
    input  logic [XLEN-1:0]            fetch_pc_i,
    output logic [XLEN-1:0]            dec_instr_o,
    output logic [XLEN-1:0]            dec_pc_o,
    input  logic                       dec_legal_i,
    output logic                       issue_valid_o,
    input  logic                       issue_ready_i,
    output logic                       trap_valid_o,
    output logic [XLEN-1:0]            trap_pc_o,
    output logic [XLEN-1:0]            trap_instr_o,
    input  logic                       trap_ack_i,
    output logic [$clog2(DEPTH+1)-1:0] count_o
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    typedef enum logic {
        S_RUN  = 1'b0,
        S_TRAP = 1'b1
    } state_e;

    state_e            state_q, state_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic              trap_valid_q, trap_valid_d;
    logic [XLEN-1:0]   trap_pc_q, trap_pc_d;
    logic [XLEN-1:0]   trap_instr_q, trap_instr_d;

    logic [XLEN-1:0]   pc_mem_q    [DEPTH];
    logic [XLEN-1:0]   instr_mem_q [DEPTH];

    logic empty_c, full_c, bypass_c, head_valid_c;
    logic push_c, pop_c, wr_en_c, rd_en_c, clear_c;

    assign empty_c = (count_q == '0);
    assign full_c  = (count_q == CNT_W'(DEPTH));

`ifdef DECODE_ISSUE_BYPASS_EN
    assign bypass_c = empty_c && (state_q == S_RUN) && !flush_i && fetch_valid_i;
`else
    assign bypass_c = 1'b0;
`endif

    assign head_valid_c = !empty_c || bypass_c;
    assign dec_instr_o  = bypass_c ? fetch_instr_i : instr_mem_q[rd_ptr_q];
    assign dec_pc_o     = bypass_c ? fetch_pc_i    : pc_mem_q[rd_ptr_q];

    // Next-state, handshake and pointer logic; flush overrides everything.
    always_comb begin
        state_d       = state_q;
        rd_ptr_d      = rd_ptr_q;
        wr_ptr_d      = wr_ptr_q;
        count_d       = count_q;
        trap_valid_d  = trap_valid_q;
        trap_pc_d     = trap_pc_q;
        trap_instr_d  = trap_instr_q;
        fetch_ready_o = 1'b0;
        issue_valid_o = 1'b0;
        clear_c       = 1'b0;

        case (state_q)
            S_RUN: begin
                fetch_ready_o = !full_c && !flush_i;
                issue_valid_o = head_valid_c && dec_legal_i && !flush_i;
                if (!flush_i && head_valid_c && !dec_legal_i) begin
                    state_d      = S_TRAP;
                    trap_valid_d = 1'b1;
                    trap_pc_d    = dec_pc_o;
                    trap_instr_d = dec_instr_o;
                end
            end
            S_TRAP: begin
                if (trap_ack_i) begin
                    state_d = S_RUN;
                    clear_c = 1'b1;
                end
            end
            default: state_d = S_RUN;
        endcase

        push_c = fetch_valid_i && fetch_ready_o;
        pop_c  = issue_valid_o && issue_ready_i;
        // A bypassed instruction that issues immediately never touches storage.
        wr_en_c = push_c && !(bypass_c && pop_c);
        rd_en_c = pop_c && !bypass_c;

        if (wr_en_c) wr_ptr_d = wr_ptr_q + PTR_W'(1);
        if (rd_en_c) rd_ptr_d = rd_ptr_q + PTR_W'(1);
        count_d = count_q + CNT_W'(wr_en_c) - CNT_W'(rd_en_c);

        if (clear_c || flush_i) begin
            state_d      = S_RUN;
            rd_ptr_d     = '0;
            wr_ptr_d     = '0;
            count_d      = '0;
            trap_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_RUN;
            rd_ptr_q     <= '0;
            wr_ptr_q     <= '0;
            count_q      <= '0;
            trap_valid_q <= 1'b0;
            trap_pc_q    <= '0;
            trap_instr_q <= '0;
        end else begin
            state_q      <= state_d;
            rd_ptr_q     <= rd_ptr_d;
            wr_ptr_q     <= wr_ptr_d;
            count_q      <= count_d;
            trap_valid_q <= trap_valid_d;
            trap_pc_q    <= trap_pc_d;
            trap_instr_q <= trap_instr_d;
        end
    end

    // Storage is intentionally not reset.
    always_ff @(posedge clk) begin
        if (wr_en_c) begin
            pc_mem_q[wr_ptr_q]    <= fetch_pc_i;
            instr_mem_q[wr_ptr_q] <= fetch_instr_i;
        end
    end

    assign trap_valid_o = trap_valid_q;
    assign trap_pc_o    = trap_pc_q;
    assign trap_instr_o = trap_instr_q;
    assign count_o      = count_q;

endmodule

// File: tb/tb_decode_issue_queue.sv
// Bench for decode_issue_queue: queue-based reference model checked every cycle plus directed literal checks.
module tb_decode_issue_queue;

    localparam int unsigned DEPTH = 4;
    localparam int unsigned XLEN  = 32;
`ifdef DECODE_ISSUE_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            flush_i = 1'b0;
    logic            fetch_valid_i = 1'b0;
    logic            fetch_ready_o;
    logic [XLEN-1:0] fetch_instr_i = '0;
    logic [XLEN-1:0] fetch_pc_i = '0;
    logic [XLEN-1:0] dec_instr_o;
    logic [XLEN-1:0] dec_pc_o;
    logic            dec_legal_i;
    logic            issue_valid_o;
    logic            issue_ready_i = 1'b0;
    logic            trap_valid_o;
    logic [XLEN-1:0] trap_pc_o;
    logic [XLEN-1:0] trap_instr_o;
    logic            trap_ack_i = 1'b0;
    logic [$clog2(DEPTH+1)-1:0] count_o;

    int checks = 0;
    int failures = 0;

    decode_issue_queue #(.DEPTH(DEPTH), .XLEN(XLEN)) dut (
        .clk(clk), .rst_n(rst_n), .flush_i(flush_i),
        .fetch_valid_i(fetch_valid_i), .fetch_ready_o(fetch_ready_o),
        .fetch_instr_i(fetch_instr_i), .fetch_pc_i(fetch_pc_i),
        .dec_instr_o(dec_instr_o), .dec_pc_o(dec_pc_o), .dec_legal_i(dec_legal_i),
        .issue_valid_o(issue_valid_o), .issue_ready_i(issue_ready_i),
        .trap_valid_o(trap_valid_o), .trap_pc_o(trap_pc_o), .trap_instr_o(trap_instr_o),
        .trap_ack_i(trap_ack_i), .count_o(count_o)
    );

    always #5 clk = ~clk;

    // Toy decoder: the all-zero word is the only illegal encoding.
    assign dec_legal_i = (dec_instr_o != '0);

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] instr;
    } ent_t;

    ent_t            mq[$];
    bit              m_trap = 1'b0;
    logic [XLEN-1:0] m_tpc = '0;
    logic [XLEN-1:0] m_tinstr = '0;
    logic [XLEN-1:0] issue_log[$];

    bit   m_empty, m_byp, m_hv, m_legal, m_rdy, m_iss, m_push, m_pop;
    ent_t m_head;

    // Reference model: compare at the falling edge, then advance to the post-edge state.
    always @(negedge clk) begin
        if (!rst_n) begin
            mq.delete();
            m_trap   = 1'b0;
            m_tpc    = '0;
            m_tinstr = '0;
        end
        m_empty = (mq.size() == 0);
        m_byp   = BYP && m_empty && !m_trap && !flush_i && fetch_valid_i;
        if (m_byp)         m_head = '{pc: fetch_pc_i, instr: fetch_instr_i};
        else if (!m_empty) m_head = mq[0];
        else               m_head = '0;
        m_hv    = !m_empty || m_byp;
        m_legal = (m_head.instr != '0);
        m_rdy   = !flush_i && !m_trap && (mq.size() < DEPTH);
        m_iss   = !flush_i && !m_trap && m_hv && m_legal;

        chk("fetch_ready", 32'(fetch_ready_o), 32'(m_rdy));
        chk("issue_valid", 32'(issue_valid_o), 32'(m_iss));
        chk("count", 32'(count_o), 32'(mq.size()));
        chk("trap_valid", 32'(trap_valid_o), 32'(m_trap));
        chk("trap_pc", trap_pc_o, m_tpc);
        chk("trap_instr", trap_instr_o, m_tinstr);
        if (m_hv) begin
            chk("dec_pc", dec_pc_o, m_head.pc);
            chk("dec_instr", dec_instr_o, m_head.instr);
        end

        if (rst_n && issue_valid_o && issue_ready_i) issue_log.push_back(dec_pc_o);

        if (rst_n) begin
            if (flush_i) begin
                mq.delete();
                m_trap = 1'b0;
            end else if (m_trap) begin
                if (trap_ack_i) begin
                    mq.delete();
                    m_trap = 1'b0;
                end
            end else begin
                m_push = fetch_valid_i && m_rdy;
                m_pop  = m_iss && issue_ready_i;
                if (!(m_byp && m_pop)) begin
                    if (m_pop)  void'(mq.pop_front());
                    if (m_push) mq.push_back('{pc: fetch_pc_i, instr: fetch_instr_i});
                end
                if (m_hv && !m_legal) begin
                    m_trap   = 1'b1;
                    m_tpc    = m_head.pc;
                    m_tinstr = m_head.instr;
                end
            end
        end
    end

    task automatic drive(input bit fv, input logic [31:0] pc, input logic [31:0] instr,
                         input bit rdy, input bit fl, input bit ack);
        fetch_valid_i = fv;
        fetch_pc_i    = pc;
        fetch_instr_i = instr;
        issue_ready_i = rdy;
        flush_i       = fl;
        trap_ack_i    = ack;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_log(input string nm, input int n,
                           input logic [31:0] e0, input logic [31:0] e1, input logic [31:0] e2,
                           input logic [31:0] e3, input logic [31:0] e4, input logic [31:0] e5);
        logic [31:0] e[6];
        e = '{e0, e1, e2, e3, e4, e5};
        chk({nm, "_len"}, 32'(issue_log.size()), 32'(n));
        if (issue_log.size() == n)
            for (int i = 0; i < n; i++) chk({nm, "_pc"}, issue_log[i], e[i]);
    endtask

    localparam logic [31:0] ADDI = 32'h0050_0093;
    localparam logic [31:0] NOP  = 32'h0000_0013;

    initial begin
        repeat (2) @(posedge clk);
        #1;
        chk("rst_count", 32'(count_o), 32'd0);
        chk("rst_fetch_ready", 32'(fetch_ready_o), 32'd1);
        chk("rst_issue_valid", 32'(issue_valid_o), 32'd0);
        chk("rst_trap_valid", 32'(trap_valid_o), 32'd0);
        rst_n = 1'b1;
        tick();

        // Single instruction latency
        issue_log.delete();
        drive(1, 32'h60, ADDI, 1, 0, 0);
        #1 chk("t1_issue_push_cycle", 32'(issue_valid_o), 32'(BYP));
        tick();
        drive(0, 0, 0, 1, 0, 0);
        #1 chk("t1_issue_next_cycle", 32'(issue_valid_o), 32'(!BYP));
`ifndef DECODE_ISSUE_BYPASS_EN
        chk("t1_dec_pc", dec_pc_o, 32'h60);
`endif
        tick();
        chk("t1_count", 32'(count_o), 32'd0);
        chk_log("t1_log", 1, 32'h60, 0, 0, 0, 0, 0);

        // Fill to full under backpressure, then drain in order
        issue_log.delete();
        for (int i = 0; i < 4; i++) begin
            drive(1, 32'(i * 4), NOP, 0, 0, 0);
            tick();
        end
        drive(0, 0, 0, 0, 0, 0);
        #1 chk("t2_count_full", 32'(count_o), 32'd4);
        chk("t2_fetch_ready_full", 32'(fetch_ready_o), 32'd0);
        chk("t2_head_pc", dec_pc_o, 32'h0);
        tick();
        drive(0, 0, 0, 1, 0, 0);
        repeat (4) tick();
        chk("t2_count_drained", 32'(count_o), 32'd0);
        chk_log("t2_log", 4, 32'h0, 32'h4, 32'h8, 32'hC, 0, 0);

        // Advance pointers mid-buffer, then fill across the wrap point
        issue_log.delete();
        drive(1, 32'h10, NOP, 1, 0, 0); tick();
        drive(1, 32'h14, NOP, 1, 0, 0); tick();
        drive(0, 0, 0, 1, 0, 0); tick();
        for (int i = 0; i < 4; i++) begin
            drive(1, 32'h18 + 32'(i * 4), NOP, 0, 0, 0);
            tick();
        end
        drive(0, 0, 0, 1, 0, 0);
        repeat (5) tick();
        chk_log("t2_wrap_log", 6, 32'h10, 32'h14, 32'h18, 32'h1C, 32'h20, 32'h24);

        // Illegal instruction raises a trap
        issue_log.delete();
        drive(1, 32'h100, NOP, 1, 0, 0);     tick();
        drive(1, 32'h104, 32'h0, 1, 0, 0);   tick();
        drive(1, 32'h108, NOP, 1, 0, 0);     tick();
        drive(0, 0, 0, 1, 0, 0);
        #1 chk("t3_trap_valid", 32'(trap_valid_o), 32'd1);
        chk("t3_trap_pc", trap_pc_o, 32'h104);
        chk("t3_trap_instr", trap_instr_o, 32'h0);
        chk("t3_fetch_ready", 32'(fetch_ready_o), 32'd0);
        chk("t3_issue_valid", 32'(issue_valid_o), 32'd0);
        chk("t3_count", 32'(count_o), BYP ? 32'd1 : 32'd2);
        tick();
        tick();
        chk("t3_trap_held", 32'(trap_valid_o), 32'd1);
        chk("t3_trap_pc_held", trap_pc_o, 32'h104);
        drive(0, 0, 0, 1, 0, 1); tick();
        drive(0, 0, 0, 1, 0, 0);
        #1 chk("t3_ack_count", 32'(count_o), 32'd0);
        chk("t3_ack_trap_valid", 32'(trap_valid_o), 32'd0);
        chk("t3_ack_fetch_ready", 32'(fetch_ready_o), 32'd1);
        tick();
        chk_log("t3_log", 1, 32'h100, 0, 0, 0, 0, 0);

        // Flush with a push offered in the same cycle
        for (int i = 0; i < 3; i++) begin
            drive(1, 32'h300 + 32'(i * 4), NOP, 0, 0, 0);
            tick();
        end
        drive(1, 32'h30C, NOP, 0, 1, 0);
        #1 chk("t4_flush_fetch_ready", 32'(fetch_ready_o), 32'd0);
        chk("t4_flush_issue_valid", 32'(issue_valid_o), 32'd0);
        tick();
        drive(0, 0, 0, 0, 0, 0);
        #1 chk("t4_count", 32'(count_o), 32'd0);
        chk("t4_issue_valid", 32'(issue_valid_o), 32'd0);
        tick();
        issue_log.delete();
        drive(1, 32'h310, NOP, 1, 0, 0); tick();
        drive(0, 0, 0, 1, 0, 0); tick();
        chk_log("t4_log", 1, 32'h310, 0, 0, 0, 0, 0);

        // Flush while trapped (with a redundant ack)
        issue_log.delete();
        drive(1, 32'h400, 32'h0, 1, 0, 0); tick();
        drive(0, 0, 0, 1, 0, 0); tick();
        #1 chk("t5_trap_valid", 32'(trap_valid_o), 32'd1);
        chk("t5_trap_pc", trap_pc_o, 32'h400);
        tick();
        drive(0, 0, 0, 1, 1, 1); tick();
        drive(1, 32'h200, NOP, 1, 0, 0);
        #1 chk("t5_trap_cleared", 32'(trap_valid_o), 32'd0);
        chk("t5_fetch_ready", 32'(fetch_ready_o), 32'd1);
        tick();
        drive(0, 0, 0, 1, 0, 0); tick();
        chk("t5_count", 32'(count_o), 32'd0);
        chk_log("t5_log", 1, 32'h200, 0, 0, 0, 0, 0);

        // Asynchronous reset with entries queued and a trap pending
        drive(1, 32'h500, 32'h0, 0, 0, 0); tick();
        drive(1, 32'h504, NOP, 0, 0, 0);   tick();
        drive(0, 0, 0, 0, 0, 0);
        #1 chk("t6_trap_before", 32'(trap_valid_o), 32'd1);
        chk("t6_count_before", 32'(count_o), BYP ? 32'd1 : 32'd2);
        #1 rst_n = 1'b0;
        #1 chk("t6_rst_count", 32'(count_o), 32'd0);
        chk("t6_rst_trap_valid", 32'(trap_valid_o), 32'd0);
        chk("t6_rst_trap_pc", trap_pc_o, 32'h0);
        chk("t6_rst_trap_instr", trap_instr_o, 32'h0);
        chk("t6_rst_fetch_ready", 32'(fetch_ready_o), 32'd1);
        chk("t6_rst_issue_valid", 32'(issue_valid_o), 32'd0);
        tick();
        rst_n = 1'b1;
        tick();
        issue_log.delete();
        drive(1, 32'h600, NOP, 1, 0, 0); tick();
        drive(0, 0, 0, 1, 0, 0); repeat (2) tick();
        chk("t6_post_count", 32'(count_o), 32'd0);
        chk_log("t6_log", 1, 32'h600, 0, 0, 0, 0, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
